// File: rtl/triangle_loader_if.sv
// triangle_loader_if: byte-stream input and triangle-RAM write port of the loader.
//   in_byte/in_valid/in_ready : upstream byte handshake (accepted on in_valid && in_ready)
//   mem_we/mem_addr/mem_wdata : one-cycle word write into the triangle RAM
//   slave modport = loader side, master modport = host/RAM side
interface triangle_loader_if #(
    parameter int ADDR_W = 13
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    modport slave  (input in_byte, in_valid, output in_ready, mem_we, mem_addr, mem_wdata);
    modport master (output in_byte, in_valid, input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/triangle_loader.sv
// triangle_loader: parses A5/count/payload byte packets into sequential 32-bit RAM writes.
//   clk, rst_n  : render clock, asynchronous active-low reset
//   hold        : feeder busy; stalls payload bytes only
//   bus         : byte stream in, RAM write port out (triangle_loader_if.slave)
//   tri_count   : triangle count of the last complete upload
//   load_done   : one-cycle pulse when tri_count is committed
//   err_len     : sticky oversize-header flag, cleared by the next valid header
module triangle_loader #(
    parameter int N_TRIS        = 712,
    parameter int WORDS_PER_TRI = 10,
    parameter int ADDR_W        = $clog2(N_TRIS*WORDS_PER_TRI),
    parameter int CNT_W         = $clog2(N_TRIS+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    triangle_loader_if.slave  bus,
    output logic [CNT_W-1:0]  tri_count,
    output logic              load_done,
    output logic              err_len
);
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, COMMIT} state_t;
    state_t            state;
    logic [7:0]        cnt_hi;
    logic [CNT_W-1:0]  cnt_lat;
    logic [15:0]       words_left;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        bidx;
    logic [23:0]       asm_q;
    logic              acc;
    logic [15:0]       count;
    // in_ready forced low while reset is asserted; hold only matters during payload
    always_comb begin
        bus.in_ready = rst_n && (state == DATA ? !hold : state != COMMIT);
        acc          = bus.in_valid && bus.in_ready;
        count        = {cnt_hi, bus.in_byte};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt_hi        <= '0;
            cnt_lat       <= '0;
            words_left    <= '0;
            addr          <= '0;
            bidx          <= '0;
            asm_q         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            tri_count     <= '0;
            load_done     <= 1'b0;
            err_len       <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            load_done  <= 1'b0;
            case (state)
                IDLE:   if (acc && bus.in_byte == 8'hA5) state <= CNT_HI;
                CNT_HI: if (acc) begin
                    cnt_hi <= bus.in_byte;
                    state  <= CNT_LO;
                end
                CNT_LO: if (acc) begin
                    if (count > 16'(N_TRIS)) begin
                        err_len <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        err_len    <= 1'b0;
                        cnt_lat    <= CNT_W'(count);
                        words_left <= count * 16'(WORDS_PER_TRI);
                        addr       <= '0;
                        bidx       <= '0;
                        state      <= count == 16'd0 ? COMMIT : DATA;
                    end
                end
                DATA: if (acc) begin
                    bidx  <= bidx + 2'd1;
                    asm_q <= {asm_q[15:0], bus.in_byte};
                    if (bidx == 2'd3) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= addr;
                        bus.mem_wdata <= {asm_q, bus.in_byte};
                        addr          <= addr + ADDR_W'(1);
                        words_left    <= words_left - 16'd1;
                        if (words_left == 16'd1) state <= COMMIT;
                    end
                end
                COMMIT: begin
                    tri_count <= cnt_lat;
                    load_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_triangle_loader.sv
// tb_triangle_loader: directed packet uploads checked against a queue-based expectation model.
module tb_triangle_loader;
    localparam int N = 712;
    localparam int W = 10;
    logic       clk = 0;
    logic       rst_n = 1;
    logic       hold = 0;
    logic [9:0] tri_count;
    logic       load_done;
    logic       err_len;
    triangle_loader_if #(.ADDR_W(13)) bus();
    triangle_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .bus       (bus),
        .tri_count (tri_count),
        .load_done (load_done),
        .err_len   (err_len)
    );
    always #5 clk = ~clk;
    int          tests = 0;
    int          fails = 0;
    int          n_writes = 0;
    int          n_done = 0;
    int          exp_tri = 0;
    logic [12:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] mem [8192];
    logic [12:0] qa [$];
    logic [31:0] qd [$];
    int          qc [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (bus.mem_we) begin
            n_writes++;
            last_addr = bus.mem_addr;
            last_data = bus.mem_wdata;
            mem[bus.mem_addr] = bus.mem_wdata;
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0h data %0h", bus.mem_addr, bus.mem_wdata);
            end else begin
                chk("mem_addr", bus.mem_addr, qa.pop_front());
                chk("mem_wdata", bus.mem_wdata, qd.pop_front());
            end
        end
        if (load_done) begin
            n_done++;
            if (qc.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_load_done: tri_count %0d", tri_count);
            end else exp_tri = qc.pop_front();
        end
        chk("tri_count", 32'(tri_count), 32'(exp_tri));
    end

    task automatic send(input logic [7:0] b);
        bit acc = 0;
        bus.in_byte  = b;
        bus.in_valid = 1;
        for (int n = 0; n < 100 && !acc; n++) begin
            #1 acc = bus.in_ready;
            @(negedge clk);
        end
        if (!acc) begin
            fails++;
            $display("FAIL send: byte %0h never accepted", b);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1);
        end
    endtask

    task automatic gap();
        if ($urandom_range(3) == 0) begin
            bus.in_valid = 0;
            repeat ($urandom_range(2, 1)) @(negedge clk);
        end
    endtask

    // mode 0: word i = base+i, mode 1: C0DE pattern, mode 2: random
    task automatic upload(input int c, input int mode, input int base, input bit gaps,
                          input int hold_word, input bit hdr_hold, input int abort_at);
        logic [31:0] w [$];
        int k = 0;
        hold = hdr_hold;
        if (c <= N) begin
            qc.push_back(c);
            for (int i = 0; i < c*W; i++) begin
                w.push_back(mode == 0 ? 32'(base + i) : mode == 1 ? 32'hC0DE_0000 + 32'(i) * 32'h0101 : $urandom());
                qa.push_back(13'(i));
                qd.push_back(w[i]);
            end
        end
        send(8'hA5);
        send(8'(c >> 8));
        send(8'(c));
        hold = 0;
        for (int i = 0; i < w.size(); i++)
            for (int b = 3; b >= 0; b--) begin
                if (k == abort_at) return;
                if (gaps) gap();
                if (i == hold_word && b == 1) begin
                    hold = 1;
                    bus.in_byte  = w[i][15:8];
                    bus.in_valid = 1;
                    repeat (7) begin
                        #1 chk("hold_in_ready", 32'(bus.in_ready), 0);
                        @(negedge clk);
                    end
                    hold = 0;
                end
                send(w[i][8*b +: 8]);
                k++;
            end
        bus.in_valid = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && (qa.size() + qc.size()) > 0; n++) @(negedge clk);
        chk("drain", 32'(qa.size() + qc.size()), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_tri_count", 32'(tri_count), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_err_len", 32'(err_len), 0);
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_byte  = 0;
        #2 rst_n = 0;
        #1 chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1 chk("idle_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);

        // single triangle, data 0..9
        upload(1, 0, 0, 0, -1, 0, -1);
        drain();
        chk("s1_writes", 32'(n_writes), 10);
        chk("s1_last_addr", 32'(last_addr), 9);
        chk("s1_last_data", last_data, 9);
        chk("s1_done", 32'(n_done), 1);
        chk("s1_tri_count", 32'(tri_count), 1);

        // oversize header 713, then zero-count packet
        send(8'hA5); send(8'h02); send(8'hC9);
        bus.in_valid = 0;
        chk("s2_err_set", 32'(err_len), 1);
        repeat (3) @(negedge clk);
        chk("s2_tri_kept", 32'(tri_count), 1);
        chk("s2_no_writes", 32'(n_writes), 10);
        qc.push_back(0);
        send(8'hA5); send(8'h00); send(8'h00);
        bus.in_valid = 0;
        chk("s2_err_clr", 32'(err_len), 0);
        chk("s2_done_early", 32'(load_done), 0);
        @(negedge clk);
        chk("s2_done", 32'(load_done), 1);
        chk("s2_tri_zero", 32'(tri_count), 0);
        chk("s2_no_writes2", 32'(n_writes), 10);

        // leading garbage bytes are dropped
        n_writes = 0;
        send(8'h12); send(8'h34);
        upload(1, 0, 0, 0, -1, 0, -1);
        drain();
        chk("s3_writes", 32'(n_writes), 10);
        chk("s3_last_data", last_data, 9);
        chk("s3_tri_count", 32'(tri_count), 1);

        // hold ignored during header, stalls mid word 3
        upload(1, 1, 0, 0, 3, 1, -1);
        drain();
        chk("s4_word3", mem[3], 32'hC0DE_0303);
        chk("s4_word9", mem[9], 32'hC0DE_0909);
        chk("s4_tri_count", 32'(tri_count), 1);

        // reset after 17 payload bytes of a count=2 upload
        upload(2, 0, 100, 0, -1, 0, 17);
        rst_n = 0;
        bus.in_valid = 0;
        #1 chk_reset_outputs();
        chk("s5_pending", 32'(qa.size()), 16);
        chk("s5_word3", mem[3], 103);
        qa.delete(); qd.delete(); qc.delete();
        exp_tri = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        upload(2, 0, 200, 0, -1, 0, -1);
        drain();
        chk("s5_tri_count", 32'(tri_count), 2);
        chk("s5_last_addr", 32'(last_addr), 19);
        chk("s5_last_data", last_data, 219);

        // full capacity with random valid gaps
        n_writes = 0;
        upload(N, 2, 0, 1, -1, 0, -1);
        drain();
        chk("s6_writes", 32'(n_writes), 7120);
        chk("s6_mem_addr", 32'(bus.mem_addr), 7119);
        chk("s6_tri_count", 32'(tri_count), 712);
        chk("s6_err_len", 32'(err_len), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/triangle_loader.md
# triangle_loader

Byte-stream receiver that loads triangle records into the triangle memory that `triangle_feeder` reads each frame. It sits between the host link's byte deserializer (upstream, valid/ready) and the write port of the triangle RAM (downstream). It assembles big-endian bytes into 32-bit words, writes them at sequential addresses, and publishes the committed triangle count only after a complete, well-formed upload.

## Interface
Parameters:
- `N_TRIS`, 712, capacity in triangles.
- `WORDS_PER_TRI`, 10, 32-bit words per record (9 q16.16 vertex coordinates + 1 color word).
- `ADDR_W`, `$clog2(N_TRIS*WORDS_PER_TRI)`, memory word-address width.
- `CNT_W`, `$clog2(N_TRIS+1)`, triangle-count width.

Ports:
- `clk`  in  1  render clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_byte`  in  8  upstream byte.
- `in_valid`  in  1  upstream byte valid.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `hold`  in  1  high while the feeder is reading memory (tie to feeder busy); stalls data writes.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  assembled word.
- `tri_count`  out  CNT_W  committed triangle count.
- `load_done`  out  1  one-cycle pulse on commit.
- `err_len`  out  1  sticky; set on oversize header, cleared by next valid header.

## Operation
- Packet: start byte 0xA5, count high byte, count low byte, then count×WORDS_PER_TRI×4 payload bytes, MSB of each word first.
- States: IDLE, CNT_HI, CNT_LO, DATA, COMMIT.
- IDLE: `in_ready`=1; 0xA5 -> CNT_HI; any other byte consumed and dropped.
- CNT_HI: store byte as count[15:8] -> CNT_LO.
- CNT_LO: form 16-bit count. count > N_TRIS -> set `err_len`, -> IDLE, no writes, `tri_count` unchanged. count == 0 -> clear `err_len`, -> COMMIT. Otherwise clear `err_len`, load words-remaining = count×WORDS_PER_TRI, word address = 0, byte index = 0 -> DATA.
- DATA: `in_ready` = !hold. Shift accepted byte into 32-bit assembly register; on fourth byte, register write (see Timing), increment address, decrement words-remaining, byte index wraps to 0. Last word -> COMMIT.
- COMMIT: `in_ready`=0; `tri_count` <= latched count, `load_done`=1 for one cycle -> IDLE.
- `tri_count` never changes outside COMMIT; a partial upload leaves the previous count in force.
- Byte index 2-bit, wraps mod 4; address never exceeds N_TRIS×WORDS_PER_TRI−1 (guaranteed by length check).

## Timing
- Reset values: state IDLE, `in_ready`=0 during reset then 1 in IDLE, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `tri_count`=0, `load_done`=0, `err_len`=0.
- `in_ready` is combinational from state and `hold`; no byte accepted while `hold`=1 in DATA; `hold` has no effect in IDLE/CNT_HI/CNT_LO.
- Write latency: `mem_we`, `mem_addr`, `mem_wdata` registered; asserted the cycle after the fourth byte of a word is accepted, for exactly one cycle. Back-to-back bytes sustain 1 word per 4 cycles.
- COMMIT entered the cycle after the last byte is accepted (same cycle as last `mem_we`); `load_done` and new `tri_count` valid the following cycle.
- Zero-count packet: `load_done` two cycles after count-low byte accepted, no `mem_we`.
- `hold` rising mid-word: assembled bytes retained; resume on `hold` falling, no byte lost or duplicated.
- `rst_n` low mid-packet: immediately abort, all outputs to reset values, count to 0; any partially written memory is left as-is.

## Test plan
- Upload count=1 (bytes A5 00 01 then 40 bytes 00 00 00 00 .. 00 00 00 09 ) -> 10 `mem_we` at addresses 0..9 with data 0..9, then `load_done` once, `tri_count`=1.
- Header A5 02 C9 (713) -> `err_len`=1, no `mem_we`, `tri_count` stays previous value; next A5 00 00 -> `err_len`=0, `load_done`, `tri_count`=0.
- Garbage 12 34 before A5 00 01 + payload -> garbage dropped, upload identical to scenario 1.
- `hold`=1 for 7 cycles after 2nd byte of word 3 -> `in_ready`=0 during hold, word 3 written with correct value at address 3 after release.
- `rst_n` low after 17 payload bytes of a count=2 upload (previous `tri_count`=1) -> outputs reset, `tri_count`=0; new full upload succeeds.
- count=712 full upload with random `in_valid` gaps -> 7120 writes, final `mem_addr`=7119, `tri_count`=712.
